// File: rtl/piso_serial_tx_if.sv
// Handshake and serial-line bundle for the framed PISO transmitter.
// The master drives the word and the load request; the slave is the transmitter.
interface piso_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             LOAD;
  logic             READY;
  logic             SO;
  logic             BUSY;
  logic             DONE;

  modport master (output D, LOAD, input READY, SO, BUSY, DONE);
  modport slave  (input D, LOAD, output READY, SO, BUSY, DONE);
endinterface

// File: rtl/piso_serial_tx.sv
// Framed parallel-in serial-out transmitter (start, WIDTH data bits LSB first, stop),
// all state on the CLK falling edge. Define PISO_TX_PARITY_EN to add an even-parity bit.
module piso_serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  piso_serial_tx_if.slave   tx
);

  localparam int TMR_W = $clog2(DIV + 1);
  localparam int IDX_W = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef PISO_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_nxt;
  logic             so_q, so_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef PISO_TX_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             tick;

  assign tick   = (tmr_q == TMR_W'(DIV - 1));
  assign sh_nxt = sh_q >> 1;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    so_d    = so_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_d   = par_q;
`endif
    // Every non-idle state holds its bit for DIV edges on the shared timer
    if (state_q != S_IDLE) tmr_d = tick ? '0 : tmr_q + TMR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (tx.LOAD && ready_q) begin
          sh_d    = tx.D;
          so_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          tmr_d   = '0;
          state_d = S_START;
`ifdef PISO_TX_PARITY_EN
          par_d   = even_parity(tx.D);
`endif
        end
      end
      S_START: begin
        if (tick) begin
          so_d    = sh_q[0];
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(WIDTH - 1)) begin
`ifdef PISO_TX_PARITY_EN
            so_d    = par_q;
            state_d = S_PARITY;
`else
            so_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            sh_d  = sh_nxt;
            so_d  = sh_nxt[0];
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          so_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          so_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        so_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(negedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      so_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      so_q    <= so_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PISO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx.SO    = so_q;
  assign tx.READY = ready_q;
  assign tx.BUSY  = busy_q;
  assign tx.DONE  = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench for piso_serial_tx: expected per-cycle line state is queued when a
// word is offered and compared at each rising edge, away from the DUT's falling edge.
module tb_piso_serial_tx;
  localparam int WIDTH = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int DIV = 1;
  localparam int PAR = 1;
`else
  localparam int DIV = 4;
  localparam int PAR = 0;
`endif
  localparam int FLEN = (WIDTH + 2 + PAR) * DIV;

  typedef struct packed {
    logic so;
    logic done;
    logic ready;
    logic busy;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  piso_serial_tx_if #(.WIDTH(WIDTH)) bus ();
  piso_serial_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (.CLK(CLK), .RST(RST), .tx(bus));

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Frame model: start 0, data LSB first, optional even parity, stop 1, then DONE sample.
  task automatic push_frame(input logic [WIDTH-1:0] d);
    logic bits[$];
    exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) bits.push_back(d[i]);
    if (PAR != 0) bits.push_back(^d);
    bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int k = 0; k < DIV; k++) begin
        e = '{so: bits[b], done: 1'b0, ready: 1'b0, busy: 1'b1};
        exp_q.push_back(e);
      end
    end
    e = '{so: 1'b1, done: 1'b1, ready: 1'b1, busy: 1'b0};
    exp_q.push_back(e);
  endtask

  function automatic logic [3:0] obs();
    return {bus.SO, bus.DONE, bus.READY, bus.BUSY};
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    bus.LOAD = 1'b0;
    bus.D = '0;
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    RST = 1'b0;
    checks++;
    if (obs() !== 4'b1010) begin
      errors++;
      $display("FAIL reset_state got={SO,DONE,READY,BUSY}=%b expected=1010", obs());
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      checks++;
      if (bus.SO !== 1'b1 || bus.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d SO=%b BUSY=%b expected SO=1 BUSY=0", i, bus.SO, bus.BUSY);
      end
    end
  endtask

  task automatic test_basic_frame();
    exp_t e;
    int n = 0;
    int dn = -1;
    push_frame(8'hA5);
    bus.D = 8'hA5;
    bus.LOAD = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge CLK);
      bus.LOAD = 1'b0;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL basic_frame k=%0d got=%b expected=%b", n, obs(), e);
      end
      if (bus.DONE === 1'b1 && dn < 0) dn = n;
      n++;
    end
    checks++;
    if (dn != FLEN) begin
      errors++;
      $display("FAIL basic_done_latency got=%0d expected=%0d", dn, FLEN);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      checks++;
      if (obs() !== 4'b1010) begin
        errors++;
        $display("FAIL basic_after_done cycle=%0d got=%b expected=1010", i, obs());
      end
    end
  endtask

  task automatic test_load_ignored();
    exp_t e;
    int n = 0;
    push_frame(8'hA5);
    bus.D = 8'hA5;
    bus.LOAD = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge CLK);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL load_ignored k=%0d got=%b expected=%b", n, obs(), e);
      end
      if (n == 9) begin
        bus.D = 8'hFF;
        bus.LOAD = 1'b1;
      end else begin
        bus.LOAD = 1'b0;
      end
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      checks++;
      if (bus.SO !== 1'b1 || bus.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL no_second_frame cycle=%0d SO=%b BUSY=%b expected SO=1 BUSY=0", i, bus.SO, bus.BUSY);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n = 0;
    int idle_cnt = 0;
    push_frame(8'h01);
    push_frame(8'h80);
    bus.D = 8'h01;
    bus.LOAD = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge CLK);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL back_to_back k=%0d got=%b expected=%b", n, obs(), e);
      end
      if (n >= FLEN - DIV + 1 && n <= FLEN + DIV && bus.BUSY === 1'b0) idle_cnt++;
      if (n == 0) bus.D = 8'h80;
      if (n == FLEN + 1) bus.LOAD = 1'b0;
      n++;
    end
    checks++;
    if (idle_cnt != 1) begin
      errors++;
      $display("FAIL back_to_back_gap got=%0d idle cycles expected=1", idle_cnt);
    end
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    int n = 0;
    push_frame(8'hA5);
    bus.D = 8'hA5;
    bus.LOAD = 1'b1;
    while (exp_q.size() > 0 && n <= DIV * 4 + 1) begin
      e = exp_q.pop_front();
      @(posedge CLK);
      bus.LOAD = 1'b0;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL midreset_prefix k=%0d got=%b expected=%b", n, obs(), e);
      end
      n++;
    end
    exp_q.delete();
    RST = 1'b1;
    @(posedge CLK);
    RST = 1'b0;
    checks++;
    if (obs() !== 4'b1010) begin
      errors++;
      $display("FAIL midreset_state got=%b expected=1010", obs());
    end
    for (int i = 0; i < FLEN + 4; i++) begin
      @(posedge CLK);
      checks++;
      if (bus.DONE !== 1'b0 || bus.SO !== 1'b1) begin
        errors++;
        $display("FAIL midreset_quiet cycle=%0d DONE=%b SO=%b expected DONE=0 SO=1", i, bus.DONE, bus.SO);
      end
    end
    n = 0;
    push_frame(8'h3C);
    bus.D = 8'h3C;
    bus.LOAD = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge CLK);
      bus.LOAD = 1'b0;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL midreset_clean k=%0d got=%b expected=%b", n, obs(), e);
      end
      n++;
    end
    repeat (2) @(posedge CLK);
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity();
    logic [WIDTH-1:0] words [2];
    logic             pbit  [2];
    exp_t e;
    int n;
    int dn;
    words[0] = 8'h07; pbit[0] = 1'b1;
    words[1] = 8'hA5; pbit[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      n = 0;
      dn = -1;
      push_frame(words[w]);
      bus.D = words[w];
      bus.LOAD = 1'b1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        @(posedge CLK);
        bus.LOAD = 1'b0;
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL parity_frame word=%h k=%0d got=%b expected=%b", words[w], n, obs(), e);
        end
        if (n == (WIDTH + 1) * DIV) begin
          checks++;
          if (bus.SO !== pbit[w]) begin
            errors++;
            $display("FAIL parity_bit word=%h got=%b expected=%b", words[w], bus.SO, pbit[w]);
          end
        end
        if (bus.DONE === 1'b1 && dn < 0) dn = n;
        n++;
      end
      checks++;
      if (dn != 11) begin
        errors++;
        $display("FAIL parity_length word=%h got=%0d expected=11", words[w], dn);
      end
      repeat (2) @(posedge CLK);
    end
  endtask
`endif

  initial begin
    RST = 1'b1;
    bus.LOAD = 1'b0;
    bus.D = '0;
    test_reset();
    test_basic_frame();
    test_load_ignored();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef PISO_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
